dds_sweep_ctrl: RTL and testbench
=================================

// Module: dds_sweep_ctrl
// PURPOSE
//  Frequency-sweep sequencer for the DDS core: drives the DDS signed phase_inc_delta input
//  through a programmable staircase (linear chirp) between two tuning offsets.
//  Sits between the control/register side and the DDS; the DDS adds this delta to its base increment.
//  Supports one-shot, repeating-sawtooth and triangle (up/down) sweeps with start/abort control.
// PARAMETERS
//  PHASE_W  10  width of tuning words; must equal the PHASE_W of the driven DDS
//  DWELL_W  16  width of the dwell counter (cycles each step is held)
// PORTS
//  clk              in   1          clock
//  rst_n            in   1          asynchronous, active-low reset
//  start            in   1          begin sweep; sampled only in IDLE
//  abort            in   1          stop sweep immediately; priority over start
//  mode             in   2          0 once, 1 repeat (sawtooth), 2 triangle, 3 = treated as 0
//  f_start          in   PHASE_W    signed first delta value
//  f_stop           in   PHASE_W    signed final delta value
//  f_step           in   PHASE_W-1  unsigned step magnitude; 0 treated as 1
//  dwell            in   DWELL_W    cycles per step; 0 treated as 1
//  phase_inc_delta  out  PHASE_W    signed registered delta to DDS
//  busy             out  1          high while sweeping
//  step_tick        out  1          1-cycle pulse on every delta update after the first
//  done             out  1          1-cycle pulse when a one-shot sweep completes
// BEHAVIOUR
//  - Reset: phase_inc_delta=0, busy=0, step_tick=0, done=0, state IDLE, dwell count 0.
//  - States: IDLE, SWEEP. All outputs registered.
//  - IDLE: on edge with start=1 and abort=0, do the following on that edge:
//    latch mode/f_start/f_stop/f_step/dwell; set phase_inc_delta=f_start and busy=1;
//    clear the counter; go to SWEEP.
//  - Latched values are fixed for the whole sweep; input changes while busy are ignored.
//  - In IDLE, phase_inc_delta holds its last value.
//  - Direction: up if f_stop >= f_start, else down. Triangle mode toggles direction at each end.
//  - SWEEP: each value is held exactly dwell_eff cycles (dwell_eff = max(dwell,1)).
//    On the edge where the counter reaches dwell_eff-1:
//      - The counter clears.
//      - next = delta +/- step_eff, computed in PHASE_W+1 signed bits.
//      - next is clamped to the current target end: f_stop going out, f_start coming back.
//  - Target end reached (delta == target when dwell expires):
//      - mode0/3: busy<=0, done<=1 for one cycle, state IDLE, delta holds target; no step_tick.
//      - mode1: delta<=f_start, step_tick=1, continue.
//      - mode2: reverse direction, step one step toward the other end (clamped), step_tick=1.
//  - f_start==f_stop:
//      - mode0: done after dwell_eff cycles.
//      - mode1/2: delta stays constant; step_tick pulses every dwell_eff cycles.
//  - start while busy: ignored.
//  - abort (any state): the next edge forces IDLE with busy=0 and counter cleared.
//    Delta holds its current value; no done pulse.
//  - Edge with both start and abort in IDLE: abort wins, so the sweep does not start.
//  - Async reset mid-sweep: immediately back to reset values.
//  - Delta never leaves [min(f_start,f_stop), max(f_start,f_stop)]; no wrap-around.
// TESTING
//  T1 once: f_start=-8 f_stop=8 f_step=4 dwell=3 mode0, start at edge N
//     -> delta -8,-4,0,4,8, each held 3 cycles; -8 is set at edge N, 8 at edge N+12
//     -> done pulses at N+15; busy falls at N+15; 4 step_ticks.
//  T2 clamp+triangle: f_start=0 f_stop=10 f_step=4 dwell=1 mode2
//     -> delta 0,4,8,10,6,2,0,4,... every cycle; never outside [0,10].
//  T3 repeat down: f_start=5 f_stop=-5 f_step=5 dwell=2 mode1
//     -> 5,0,-5,5,0,-5,... each held 2 cycles; done never asserts.
//  T4 degenerate: f_step=0, dwell=0, f_start=0, f_stop=3, mode0
//     -> 0,1,2,3 on successive cycles, then done.
//  T5 abort/priority:
//     -> abort mid-sweep at delta=4 -> busy=0 next edge, delta stays 4, no done.
//     -> start+abort in the same cycle -> stays IDLE.
//     -> start while busy -> no restart.
//  T6 reset: assert rst_n=0 mid-sweep -> all outputs 0 asynchronously.
//     -> after release, a new start sweeps correctly from f_start.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the DDS phase_inc_delta through a clamped staircase
// between two signed tuning offsets in one-shot, sawtooth or triangle mode.
module dds_sweep_ctrl #(
    parameter int PHASE_W = 10,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         mode,
    input  logic [PHASE_W-1:0] f_start,
    input  logic [PHASE_W-1:0] f_stop,
    input  logic [PHASE_W-2:0] f_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [PHASE_W-1:0] phase_inc_delta,
    output logic               busy,
    output logic               step_tick,
    output logic               done
);

    typedef enum logic {S_IDLE, S_SWEEP} state_t;

    state_t r_state, w_state_nxt;

    logic [1:0]         r_mode,     w_mode_nxt;
    logic [PHASE_W-1:0] r_start,    w_start_nxt;
    logic [PHASE_W-1:0] r_stop,     w_stop_nxt;
    logic [PHASE_W-2:0] r_step,     w_step_nxt;
    logic [DWELL_W-1:0] r_dwell_m1, w_dwell_m1_nxt;
    logic [DWELL_W-1:0] r_cnt,      w_cnt_nxt;
    logic [PHASE_W-1:0] r_delta,    w_delta_nxt;
    logic               r_up,       w_up_nxt;
    logic               r_out,      w_out_nxt;
    logic               r_busy,     w_busy_nxt;
    logic               r_tick,     w_tick_nxt;
    logic               r_done,     w_done_nxt;

    logic                      w_start_req;
    logic                      w_expire;
    logic                      w_at_target;
    logic                      w_once;
    logic                      w_moving_up;
    logic signed [PHASE_W:0]   w_cur;
    logic signed [PHASE_W:0]   w_step_x;
    logic signed [PHASE_W:0]   w_up_val;
    logic signed [PHASE_W:0]   w_dn_val;
    logic signed [PHASE_W:0]   w_tgt;
    logic signed [PHASE_W:0]   w_rev_tgt;
    logic signed [PHASE_W:0]   w_fwd;
    logic signed [PHASE_W:0]   w_rev;
    logic signed [PHASE_W-1:0] w_in_start;
    logic signed [PHASE_W-1:0] w_in_stop;

    function automatic logic signed [PHASE_W:0] sx(input logic [PHASE_W-1:0] v);
        return {v[PHASE_W-1], v};
    endfunction

    assign w_start_req = start && !abort;
    assign w_in_start  = f_start;
    assign w_in_stop   = f_stop;
    assign w_expire    = (r_cnt == r_dwell_m1);
    assign w_once      = !(r_mode == 2'd1 || r_mode == 2'd2);
    // r_out: heading towards f_stop; only triangle mode ever clears it on the way back
    assign w_moving_up = r_out ? r_up : !r_up;
    assign w_at_target = (r_delta == (r_out ? r_stop : r_start));

    assign w_cur     = sx(r_delta);
    assign w_step_x  = {2'b00, r_step};
    assign w_up_val  = w_cur + w_step_x;
    assign w_dn_val  = w_cur - w_step_x;
    assign w_tgt     = sx(r_out ? r_stop : r_start);
    assign w_rev_tgt = sx(r_out ? r_start : r_stop);

    always_comb begin
        if (w_moving_up) begin
            w_fwd = (w_up_val > w_tgt)     ? w_tgt     : w_up_val;
            w_rev = (w_dn_val < w_rev_tgt) ? w_rev_tgt : w_dn_val;
        end else begin
            w_fwd = (w_dn_val < w_tgt)     ? w_tgt     : w_dn_val;
            w_rev = (w_up_val > w_rev_tgt) ? w_rev_tgt : w_up_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_req) w_state_nxt = S_SWEEP;
            S_SWEEP: begin
                if (abort)                                w_state_nxt = S_IDLE;
                else if (w_expire && w_at_target && w_once) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_mode_nxt     = r_mode;
        w_start_nxt    = r_start;
        w_stop_nxt     = r_stop;
        w_step_nxt     = r_step;
        w_dwell_m1_nxt = r_dwell_m1;
        w_cnt_nxt      = r_cnt;
        w_delta_nxt    = r_delta;
        w_up_nxt       = r_up;
        w_out_nxt      = r_out;
        w_busy_nxt     = r_busy;
        w_tick_nxt     = 1'b0;
        w_done_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_req) begin
                    w_mode_nxt     = mode;
                    w_start_nxt    = f_start;
                    w_stop_nxt     = f_stop;
                    w_step_nxt     = (f_step == '0) ? (PHASE_W-1)'(1) : f_step;
                    w_dwell_m1_nxt = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
                    w_cnt_nxt      = '0;
                    w_delta_nxt    = f_start;
                    w_up_nxt       = (w_in_stop >= w_in_start);
                    w_out_nxt      = 1'b1;
                    w_busy_nxt     = 1'b1;
                end
            end
            S_SWEEP: begin
                if (abort) begin
                    w_busy_nxt = 1'b0;
                    w_cnt_nxt  = '0;
                end else if (w_expire) begin
                    w_cnt_nxt = '0;
                    if (!w_at_target) begin
                        w_delta_nxt = w_fwd[PHASE_W-1:0];
                        w_tick_nxt  = 1'b1;
                    end else if (w_once) begin
                        w_busy_nxt = 1'b0;
                        w_done_nxt = 1'b1;
                    end else if (r_mode == 2'd1) begin
                        w_delta_nxt = r_start;
                        w_tick_nxt  = 1'b1;
                    end else begin
                        w_out_nxt   = !r_out;
                        w_delta_nxt = w_rev[PHASE_W-1:0];
                        w_tick_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + DWELL_W'(1);
                end
            end
            default: w_busy_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode     <= '0;
            r_start    <= '0;
            r_stop     <= '0;
            r_step     <= '0;
            r_dwell_m1 <= '0;
            r_cnt      <= '0;
            r_delta    <= '0;
            r_up       <= 1'b0;
            r_out      <= 1'b0;
            r_busy     <= 1'b0;
            r_tick     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_mode     <= w_mode_nxt;
            r_start    <= w_start_nxt;
            r_stop     <= w_stop_nxt;
            r_step     <= w_step_nxt;
            r_dwell_m1 <= w_dwell_m1_nxt;
            r_cnt      <= w_cnt_nxt;
            r_delta    <= w_delta_nxt;
            r_up       <= w_up_nxt;
            r_out      <= w_out_nxt;
            r_busy     <= w_busy_nxt;
            r_tick     <= w_tick_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign phase_inc_delta = r_delta;
    assign busy            = r_busy;
    assign step_tick       = r_tick;
    assign done            = r_done;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: hand-computed delta sequences for each sweep mode,
// clamping, degenerate step/dwell, abort/start priority and asynchronous reset.
module tb_dds_sweep_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [1:0] mode;
    logic [9:0] f_start;
    logic [9:0] f_stop;
    logic [8:0] f_step;
    logic [15:0] dwell;
    logic [9:0] phase_inc_delta;
    logic       busy;
    logic       step_tick;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    dds_sweep_ctrl #(.PHASE_W(10), .DWELL_W(16)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .mode           (mode),
        .f_start        (f_start),
        .f_stop         (f_stop),
        .f_step         (f_step),
        .dwell          (dwell),
        .phase_inc_delta(phase_inc_delta),
        .busy           (busy),
        .step_tick      (step_tick),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input integer obs, input integer exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int m, input int fs, input int fe, input int st, input int dw);
        mode    = 2'(m);
        f_start = 10'(fs);
        f_stop  = 10'(fe);
        f_step  = 9'(st);
        dwell   = 16'(dw);
    endtask

    function automatic integer dlt();
        return $signed(phase_inc_delta);
    endfunction

    int ticks;
    int exp_d;
    int tri_seq [11] = '{0, 4, 8, 10, 6, 2, 0, 4, 8, 10, 6};
    int saw_seq [3]  = '{5, 0, -5};

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        set_cfg(0, 0, 0, 0, 0);
        #12;
        check("rst_delta", dlt(), 0);
        check("rst_busy", busy, 0);
        check("rst_tick", step_tick, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        step_clk();

        // T1: one-shot -8..8 step 4 dwell 3
        set_cfg(0, -8, 8, 4, 3);
        start = 1'b1;
        step_clk();
        start = 1'b0;
        check("t1_first", dlt(), -8);
        check("t1_busy0", busy, 1);
        ticks = 0;
        for (int k = 1; k <= 15; k++) begin
            step_clk();
            exp_d = -8 + 4 * ((k / 3 > 4) ? 4 : k / 3);
            check($sformatf("t1_delta_%0d", k), dlt(), exp_d);
            check($sformatf("t1_busy_%0d", k), busy, (k < 15) ? 1 : 0);
            check($sformatf("t1_done_%0d", k), done, (k == 15) ? 1 : 0);
            if (step_tick) ticks++;
        end
        check("t1_ticks", ticks, 4);
        step_clk();
        check("t1_done_pulse", done, 0);
        check("t1_hold", dlt(), 8);

        // T2: triangle with clamp
        set_cfg(2, 0, 10, 4, 1);
        start = 1'b1;
        step_clk();
        start = 1'b0;
        check("t2_first", dlt(), 0);
        for (int k = 1; k < 11; k++) begin
            step_clk();
            check($sformatf("t2_delta_%0d", k), dlt(), tri_seq[k]);
            check($sformatf("t2_tick_%0d", k), step_tick, 1);
        end
        abort = 1'b1;
        step_clk();
        abort = 1'b0;
        check("t2_abort_busy", busy, 0);
        check("t2_abort_hold", dlt(), 6);

        // T3: repeating downward sawtooth
        set_cfg(1, 5, -5, 5, 2);
        start = 1'b1;
        step_clk();
        start = 1'b0;
        check("t3_first", dlt(), 5);
        for (int k = 1; k <= 12; k++) begin
            step_clk();
            check($sformatf("t3_delta_%0d", k), dlt(), saw_seq[(k / 2) % 3]);
            check($sformatf("t3_done_%0d", k), done, 0);
        end
        abort = 1'b1;
        step_clk();
        abort = 1'b0;
        check("t3_abort_busy", busy, 0);

        // T4: zero step and zero dwell behave as 1
        set_cfg(0, 0, 3, 0, 0);
        start = 1'b1;
        step_clk();
        start = 1'b0;
        check("t4_first", dlt(), 0);
        for (int k = 1; k <= 3; k++) begin
            step_clk();
            check($sformatf("t4_delta_%0d", k), dlt(), k);
        end
        step_clk();
        check("t4_done", done, 1);
        check("t4_busy", busy, 0);
        check("t4_hold", dlt(), 3);

        // T5: start while busy ignored, abort at delta 4, start+abort in idle
        set_cfg(0, 0, 20, 4, 2);
        start = 1'b1;
        step_clk();
        check("t5_first", dlt(), 0);
        set_cfg(0, -20, 20, 1, 1);
        step_clk();
        start = 1'b0;
        check("t5_norestart1", dlt(), 0);
        step_clk();
        check("t5_norestart2", dlt(), 4);
        step_clk();
        check("t5_pre_abort", dlt(), 4);
        abort = 1'b1;
        step_clk();
        abort = 1'b0;
        check("t5_abort_busy", busy, 0);
        check("t5_abort_hold", dlt(), 4);
        check("t5_abort_done", done, 0);
        step_clk();
        check("t5_idle_done", done, 0);
        check("t5_idle_hold", dlt(), 4);
        start = 1'b1;
        abort = 1'b1;
        step_clk();
        start = 1'b0;
        abort = 1'b0;
        check("t5_both_busy", busy, 0);
        check("t5_both_hold", dlt(), 4);

        // T6: asynchronous reset mid-sweep, then a fresh sweep
        set_cfg(0, -8, 8, 4, 3);
        start = 1'b1;
        step_clk();
        start = 1'b0;
        step_clk();
        step_clk();
        step_clk();
        check("t6_pre_rst", dlt(), -4);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_delta", dlt(), 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_tick", step_tick, 0);
        step_clk();
        rst_n = 1'b1;
        set_cfg(0, 7, 9, 1, 1);
        start = 1'b1;
        step_clk();
        start = 1'b0;
        check("t6_first", dlt(), 7);
        step_clk();
        check("t6_d1", dlt(), 8);
        step_clk();
        check("t6_d2", dlt(), 9);
        step_clk();
        check("t6_done", done, 1);
        check("t6_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
